// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : RV64 fetch stage. Owns the PC and the IF/ID register, and
//               handles redirects, flush, stall, halt and the fetch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter logic [63:0] END_ADDR = 64'd64,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] Instruction,
    output logic [63:0] Instruction_address,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_valid,
    output logic        halted,
    output logic        fetch_error,
    output logic [31:0] fetch_count
);

    logic [63:0] r_pc;
    logic [63:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic        r_fetch_error;
    logic [31:0] r_fetch_count;

    logic [63:0] w_pc_next;
    logic        w_halted;
    logic        w_redirect;
    logic        w_misaligned;

    assign w_pc_next    = r_pc + 64'd4;
    assign w_halted     = r_fetch_error || (r_pc >= END_ADDR);
    // Once a misaligned redirect has poisoned fetch, later redirects are dead.
    assign w_redirect   = branch_taken && !r_fetch_error;
    assign w_misaligned = (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_ifid_pc     <= 64'd0;
            r_ifid_instr  <= NOP;
            r_ifid_valid  <= 1'b0;
            r_fetch_error <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (w_redirect) begin
            if (w_misaligned) begin
                r_fetch_error <= 1'b1;
            end else begin
                r_pc <= branch_target;
            end
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
        end else if (flush) begin
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
            if (!stall && !w_halted) begin
                r_pc <= w_pc_next;
            end
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (w_halted) begin
            // Address is still shown, but the returned word is not captured.
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_instr  <= Instruction;
            r_ifid_pc     <= r_pc;
            r_ifid_valid  <= 1'b1;
            r_pc          <= w_pc_next;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign Instruction_address = r_pc;
    assign IFID_PC             = r_ifid_pc;
    assign IFID_Instruction    = r_ifid_instr;
    assign IFID_valid          = r_ifid_valid;
    assign halted              = w_halted;
    assign fetch_error         = r_fetch_error;
    assign fetch_count         = r_fetch_count;

endmodule
`default_nettype wire
